// File: rtl/burst_mem_responder.sv
// Burst read/write responder backed by an on-chip SRAM window at BASE_ADDR.
// One command at a time; write beats stream in, read beats stream out through a two-stage pipe.
module burst_mem_responder #(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 64,
    parameter int                DEPTH     = 16384,
    parameter int                LEN_W     = 15,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              err
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_FIN} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [LEN_W-1:0]  remaining;
    logic              err_acc;

    // SRAM output stage: one word in flight between the array and the output register
    logic              q_valid;
    logic              q_last;
    logic              q_zero;
    logic [DATA_W-1:0] mem_q;

    logic [ADDR_W-1:0] cmd_idx;
    logic [ADDR_W-1:0] ra;
    logic              cmd_fire;
    logic              wr_fire;
    logic              rd_fire;
    logic              load_out;
    logic              issue;
    logic              ra_ok;
    logic              idx_ok;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign wr_fire  = wr_valid & wr_ready;
    assign rd_fire  = rd_valid & rd_ready;
    assign cmd_idx  = (cmd_addr - BASE_ADDR) >> 3;
    assign idx_ok   = idx < ADDR_W'(DEPTH);
    assign load_out = q_valid & (~rd_valid | rd_ready);

    // The first read is issued straight from the command so data lands two cycles after accept
    assign issue = (state == S_IDLE)
                 ? (cmd_fire & ~cmd_write & (cmd_len != '0))
                 : ((state == S_READ) & (remaining != '0) & (~q_valid | load_out));
    assign ra    = (state == S_IDLE) ? cmd_idx : idx;
    assign ra_ok = (ra < ADDR_W'(DEPTH)) & ~((state == S_IDLE) & (cmd_addr < BASE_ADDR));

    always_ff @(posedge clk) begin
        if (!rst && state == S_WRITE && wr_fire && idx_ok)
            mem[idx[IDX_W-1:0]] <= wr_data;
        if (issue)
            mem_q <= mem[ra[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            idx       <= '0;
            remaining <= '0;
            err_acc   <= 1'b0;
            q_valid   <= 1'b0;
            q_last    <= 1'b0;
            q_zero    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready <= 1'b0;
                        err_acc   <= (cmd_addr[2:0] != 3'b0) | (cmd_addr < BASE_ADDR) | (issue & ~ra_ok);
                        idx       <= issue ? cmd_idx + ADDR_W'(1) : cmd_idx;
                        remaining <= issue ? cmd_len - LEN_W'(1) : cmd_len;
                        if (cmd_len == '0) begin
                            state <= S_FIN;
                        end else if (cmd_write) begin
                            state    <= S_WRITE;
                            wr_ready <= 1'b1;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_fire) begin
                        idx       <= idx + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (!idx_ok)
                            err_acc <= 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            wr_ready <= 1'b0;
                            state    <= S_FIN;
                            done     <= 1'b1;
                            err      <= err_acc | ~idx_ok;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        idx       <= idx + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (!ra_ok)
                            err_acc <= 1'b1;
                    end
                    if (rd_fire) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        if (rd_last) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                            err   <= err_acc;
                        end
                    end
                    if (load_out) begin
                        rd_valid <= 1'b1;
                        rd_data  <= q_zero ? '0 : mem_q;
                        rd_last  <= q_last;
                    end
                end
                S_FIN: begin
                    // Entered with done already set after data bursts; zero-length bursts set it here
                    if (done) begin
                        done      <= 1'b0;
                        err       <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        done <= 1'b1;
                        err  <= err_acc;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (issue) begin
                q_valid <= 1'b1;
                q_last  <= (state == S_IDLE) ? (cmd_len == LEN_W'(1)) : (remaining == LEN_W'(1));
                q_zero  <= ~ra_ok;
            end else if (load_out) begin
                q_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: drivers push expected beats/done flags,
// a negedge monitor pops and compares whenever the DUT presents a read beat or done.
module tb_burst_mem_responder;
    localparam int          DATA_W = 64;
    localparam int          ADDR_W = 64;
    localparam int          DEPTH  = 16384;
    localparam int          LEN_W  = 15;
    localparam logic [63:0] BASE   = 64'h0;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              done;
    logic              err;

    burst_mem_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    int          total = 0;
    int          bad   = 0;
    beat_t       exp_rd[$];
    bit          exp_done[$];
    logic [63:0] mdl[longint];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic longint word_of(input logic [63:0] a);
        return longint'((a - BASE) >> 3);
    endfunction

    function automatic bit in_win(input longint w);
        return (w >= 0) && (w < DEPTH);
    endfunction

    // ---------------- monitor ----------------
    logic [63:0] prev_data;
    logic        prev_last;
    bit          prev_stall = 0;
    bit          b2b_watch  = 0;
    bit          b2b_done_seen = 0;
    beat_t       mon_b;
    bit          mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && rd_valid) begin
                chk("stall_data_stable", rd_data, prev_data);
                chk("stall_last_stable", rd_last, prev_last);
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            prev_last  = rd_last;
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected actual=%h required=no_beat", rd_data);
                end else begin
                    mon_b = exp_rd.pop_front();
                    chk("rd_data", rd_data, mon_b.data);
                    chk("rd_last", rd_last, mon_b.last);
                end
            end
            if (done) begin
                if (b2b_watch) b2b_done_seen = 1;
                if (exp_done.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected actual=1 required=0");
                end else begin
                    mon_e = exp_done.pop_front();
                    chk("done_err", err, mon_e);
                end
            end
            if (b2b_watch && cmd_ready)
                chk("b2b_ready_after_done", b2b_done_seen, 1);
        end
    end

    // ---------------- drivers ----------------
    task automatic send_cmd(input bit w, input logic [63:0] a, input int len);
        int k = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = LEN_W'(len);
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            k++;
            if (k > 50) begin
                chk("cmd_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wr_beats(input logic [63:0] d[$], input int len);
        int n = 0, k = 0;
        bit hs;
        while (n < len && k < 1000) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = d[n];
            @(negedge clk);
            hs = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (hs) n++;
            k++;
        end
        wr_valid = 0;
        chk("wr_beat_count", n, len);
    endtask

    task automatic rd_beats(input int len, input int mode);
        int n = 0, k = 0, first = -1;
        bit hs;
        while (n < len && k < 2000) begin
            case (mode)
                0:       rd_ready = 1;
                1:       rd_ready = (k % 3 == 0);
                default: rd_ready = $urandom_range(0, 1);
            endcase
            @(negedge clk);
            if (first < 0 && rd_valid) first = k;
            hs = rd_valid && rd_ready;
            @(posedge clk); #1;
            if (hs) n++;
            k++;
        end
        rd_ready = 0;
        chk("rd_first_valid_cycle", first, 1);
        chk("rd_beat_count", n, len);
    endtask

    task automatic wait_done();
        int k = 0;
        bit seen = 0;
        while (!seen && k < 10) begin
            @(negedge clk);
            if (k == 0) chk("rd_valid_after_last", rd_valid, 0);
            seen = done;
            k++;
        end
        chk("done_seen", seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic finish_len0();
        @(negedge clk);
        chk("len0_done_early", done, 0);
        chk("len0_no_wr", wr_ready, 0);
        chk("len0_no_rd", rd_valid, 0);
        @(negedge clk);
        chk("len0_done", done, 1);
        chk("len0_no_wr2", wr_ready, 0);
        @(posedge clk); #1;
    endtask

    task automatic plan_write(input logic [63:0] a, input int len, input int pat, input int keep,
                              output logic [63:0] d[$], output bit e);
        longint w0 = word_of(a);
        d = {};
        e = (a[2:0] != 3'b0);
        for (int i = 0; i < len; i++) begin
            d.push_back(pat >= 0 ? 64'(pat + i) : {$urandom, $urandom});
            if (!in_win(w0 + i)) e = 1;
            else if (i < keep) mdl[w0 + i] = d[i];
        end
    endtask

    task automatic plan_read(input logic [63:0] a, input int len, output bit e);
        longint w0 = word_of(a);
        beat_t  b;
        e = (a[2:0] != 3'b0);
        for (int i = 0; i < len; i++) begin
            if (in_win(w0 + i)) b.data = mdl.exists(w0 + i) ? mdl[w0 + i] : 64'h0;
            else begin b.data = 64'h0; e = 1; end
            b.last = (i == len - 1);
            exp_rd.push_back(b);
        end
    endtask

    task automatic do_write(input logic [63:0] a, input int len, input int pat);
        logic [63:0] d[$];
        bit e;
        plan_write(a, len, pat, len, d, e);
        exp_done.push_back(e);
        send_cmd(1, a, len);
        if (len == 0) finish_len0();
        else begin
            wr_beats(d, len);
            @(negedge clk);
            chk("wr_done_latency", done, 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_read(input logic [63:0] a, input int len, input int mode);
        bit e;
        plan_read(a, len, e);
        exp_done.push_back(e);
        send_cmd(0, a, len);
        if (len == 0) finish_len0();
        else begin
            rd_beats(len, mode);
            wait_done();
        end
    endtask

    // ---------------- main sequence ----------------
    logic [63:0] d[$];
    bit          e;
    int          rlen;
    longint      rw;
    logic [63:0] ra;
    bit          got;

    initial begin
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_data", rd_data, 0);
        @(posedge clk); #1;
        rst = 0;

        do_write(BASE, 4, 'hA0);
        do_read(BASE, 4, 0);
        do_write(BASE + 64'd32, 28, -1);
        do_write(BASE + 64'(DEPTH - 16) * 8, 16, -1);
        do_read(BASE, 8, 1);
        do_write(BASE + 64'(DEPTH - 2) * 8, 3, -1);
        do_read(BASE + 64'(DEPTH - 2) * 8, 3, 2);
        do_read(BASE + 64'h4, 2, 0);
        do_read(BASE, 0, 0);
        do_write(BASE + 64'd8, 0, -1);

        // abort a 10-beat write after 5 beats
        plan_write(BASE + 64'd800, 10, -1, 5, d, e);
        send_cmd(1, BASE + 64'd800, 10);
        wr_beats(d, 5);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_cmd_ready", cmd_ready, 0);
        chk("abort_wr_ready", wr_ready, 0);
        chk("abort_rd_valid", rd_valid, 0);
        chk("abort_rd_last", rd_last, 0);
        chk("abort_rd_data", rd_data, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        @(posedge clk); #1;
        do_read(BASE + 64'd800, 5, 0);

        // back-to-back: second command waits behind the first burst's done
        plan_write(BASE + 64'd320, 2, -1, 2, d, e);
        exp_done.push_back(e);
        plan_read(BASE + 64'd320, 2, e);
        exp_done.push_back(e);
        cmd_valid = 1; cmd_write = 1; cmd_addr = BASE + 64'd320; cmd_len = LEN_W'(2);
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = cmd_ready;
        end
        @(posedge clk); #1;
        cmd_write = 0;
        b2b_done_seen = 0;
        b2b_watch = 1;
        wr_beats(d, 2);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = cmd_ready;
        end
        chk("b2b_second_accepted", got, 1);
        @(posedge clk); #1;
        cmd_valid = 0;
        b2b_watch = 0;
        rd_beats(2, 0);
        wait_done();

        for (int i = 0; i < 40; i++) begin
            rlen = $urandom_range(0, 11);
            if ($urandom_range(0, 1) == 1) rw = longint'($urandom_range(0, 20));
            else rw = longint'(DEPTH - 12) + longint'($urandom_range(0, 14));
            ra = BASE + 64'(rw) * 8;
            if ($urandom_range(0, 3) == 0) ra = ra + 64'($urandom_range(1, 7));
            if ($urandom_range(0, 1) == 1) do_write(ra, rlen, -1);
            else do_read(ra, rlen, $urandom_range(0, 2));
        end

        repeat (4) @(posedge clk);
        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
